// File: rtl/retire_queue.sv
// retire_queue: in-order retire buffer behind the dual-issue writeback stage.
//
// It hands out scoreboard IDs (sids) at issue time. It captures up to two out-of-order
// writebacks per cycle, each tagged by sid. It retires up to two completed entries per
// cycle, oldest first, onto two registered register-file write ports.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   alloc0_req_i / alloc1_req_i allocation requests (older / younger issuing instruction)
//   alloc_ready_o               at least two free entries
//   alloc0_sid_o / alloc1_sid_o sids granted to alloc0 (tail) and alloc1 (tail+1)
//   instN_wb_*_i                writeback N: valid, rd, value, sid
//   flush_i                     redirect flush, clears all in-flight entries
//   rf_weN_o / rf_waddrN_o / rf_wdataN_o  retire port N (port 0 carries the older entry)
//   retire_cnt_o                entries retired this cycle, including rd=0 entries
//   empty_o                     no entries allocated
module retire_queue #(
  parameter int unsigned SID_W = 3,
  parameter int unsigned XLEN  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc0_req_i,
  input  logic             alloc1_req_i,
  output logic             alloc_ready_o,
  output logic [SID_W:0]   alloc0_sid_o,
  output logic [SID_W:0]   alloc1_sid_o,
  input  logic             inst0_wb_valid_i,
  input  logic [4:0]       inst0_wb_rd_i,
  input  logic [XLEN-1:0]  inst0_wb_value_i,
  input  logic [SID_W:0]   inst0_wb_sid_i,
  input  logic             inst1_wb_valid_i,
  input  logic [4:0]       inst1_wb_rd_i,
  input  logic [XLEN-1:0]  inst1_wb_value_i,
  input  logic [SID_W:0]   inst1_wb_sid_i,
  input  logic             flush_i,
  output logic             rf_we0_o,
  output logic [4:0]       rf_waddr0_o,
  output logic [XLEN-1:0]  rf_wdata0_o,
  output logic             rf_we1_o,
  output logic [4:0]       rf_waddr1_o,
  output logic [XLEN-1:0]  rf_wdata1_o,
  output logic [1:0]       retire_cnt_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 1 << SID_W;

  typedef logic [SID_W:0]   sid_t;
  typedef logic [SID_W-1:0] idx_t;

  sid_t             head_q, head_d, tail_q, tail_d;
  logic [Depth-1:0] valid_q, valid_d, done_q, done_d, wrap_q, wrap_d;
  logic [4:0]       rd_q  [Depth];
  logic [4:0]       rd_d  [Depth];
  logic [XLEN-1:0]  val_q [Depth];
  logic [XLEN-1:0]  val_d [Depth];

  logic             we0_q, we0_d, we1_q, we1_d;
  logic [4:0]       waddr0_q, waddr0_d, waddr1_q, waddr1_d;
  logic [XLEN-1:0]  wdata0_q, wdata0_d, wdata1_q, wdata1_d;
  logic [1:0]       cnt_q, cnt_d;

  sid_t             count, tail1;
  logic [SID_W+1:0] free_slots;
  idx_t             h0, h1, t0, t1, wb0_idx, wb1_idx;
  logic             r0, r1, alloc_ok, wb0_hit, wb1_hit;

  // Occupancy and retire decision come from registered state only.
  assign count         = tail_q - head_q;
  assign free_slots    = (SID_W+2)'(Depth) - {1'b0, count};
  assign alloc_ready_o = free_slots >= (SID_W+2)'(2);
  assign empty_o       = head_q == tail_q;
  assign alloc0_sid_o  = tail_q;
  assign tail1         = tail_q + sid_t'(1);
  assign alloc1_sid_o  = tail1;

  assign h0 = head_q[SID_W-1:0];
  assign h1 = h0 + idx_t'(1);
  assign t0 = tail_q[SID_W-1:0];
  assign t1 = tail1[SID_W-1:0];
  assign r0 = valid_q[h0] & done_q[h0];
  assign r1 = r0 & valid_q[h1] & done_q[h1];

  assign alloc_ok = alloc0_req_i & alloc_ready_o & ~flush_i;

  // A stale sid (same index, other wrap bit) must not complete the live entry.
  assign wb0_idx = inst0_wb_sid_i[SID_W-1:0];
  assign wb1_idx = inst1_wb_sid_i[SID_W-1:0];
  assign wb0_hit = inst0_wb_valid_i & valid_q[wb0_idx] & (wrap_q[wb0_idx] == inst0_wb_sid_i[SID_W]);
  assign wb1_hit = inst1_wb_valid_i & valid_q[wb1_idx] & (wrap_q[wb1_idx] == inst1_wb_sid_i[SID_W]);

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    valid_d  = valid_q;
    done_d   = done_q;
    wrap_d   = wrap_q;
    rd_d     = rd_q;
    val_d    = val_q;
    we0_d    = 1'b0;
    we1_d    = 1'b0;
    waddr0_d = '0;
    waddr1_d = '0;
    wdata0_d = '0;
    wdata1_d = '0;
    cnt_d    = 2'd0;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      // Port 1 is applied last so it wins on a duplicate sid.
      if (wb0_hit) begin
        done_d[wb0_idx] = 1'b1;
        rd_d[wb0_idx]   = inst0_wb_rd_i;
        val_d[wb0_idx]  = inst0_wb_value_i;
      end
      if (wb1_hit) begin
        done_d[wb1_idx] = 1'b1;
        rd_d[wb1_idx]   = inst1_wb_rd_i;
        val_d[wb1_idx]  = inst1_wb_value_i;
      end
      // Retire clears after capture, so a late writeback to a retiring entry is lost.
      if (r0) begin
        we0_d       = rd_q[h0] != 5'd0;
        waddr0_d    = rd_q[h0];
        wdata0_d    = val_q[h0];
        valid_d[h0] = 1'b0;
        done_d[h0]  = 1'b0;
      end
      if (r1) begin
        we1_d       = rd_q[h1] != 5'd0;
        waddr1_d    = rd_q[h1];
        wdata1_d    = val_q[h1];
        valid_d[h1] = 1'b0;
        done_d[h1]  = 1'b0;
      end
      // r1 implies r0, so the count is {r1, r0 & ~r1}.
      cnt_d  = {r1, r0 & ~r1};
      head_d = head_q + sid_t'(cnt_d);
      if (alloc_ok) begin
        valid_d[t0] = 1'b1;
        done_d[t0]  = 1'b0;
        wrap_d[t0]  = tail_q[SID_W];
        if (alloc1_req_i) begin
          valid_d[t1] = 1'b1;
          done_d[t1]  = 1'b0;
          wrap_d[t1]  = tail1[SID_W];
        end
        tail_d = tail_q + (alloc1_req_i ? sid_t'(2) : sid_t'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      wrap_q   <= '0;
      for (int i = 0; i < Depth; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
      end
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      cnt_q    <= 2'd0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      rd_q     <= rd_d;
      val_q    <= val_d;
      we0_q    <= we0_d;
      we1_q    <= we1_d;
      waddr0_q <= waddr0_d;
      waddr1_q <= waddr1_d;
      wdata0_q <= wdata0_d;
      wdata1_q <= wdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rf_we0_o     = we0_q;
  assign rf_waddr0_o  = waddr0_q;
  assign rf_wdata0_o  = wdata0_q;
  assign rf_we1_o     = we1_q;
  assign rf_waddr1_o  = waddr1_q;
  assign rf_wdata1_o  = wdata1_q;
  assign retire_cnt_o = cnt_q;

endmodule
